// File: rtl/trigger_issue_tracker_pkg.sv
// Shared control definitions for the PE trigger/issue path: instruction
// table sizing and the per-stage issue record.
package trigger_issue_tracker_pkg;

  localparam int TIA_MAX_NUM_INSTRUCTIONS    = 16;
  localparam int TIA_INSTRUCTION_INDEX_WIDTH = 5;

  typedef struct packed {
    logic                                   valid;
    logic [TIA_INSTRUCTION_INDEX_WIDTH-1:0] index;
  } issue_stage_t;

endpackage

// File: rtl/trigger_issue_tracker_instruction_index_decoder.sv
// Index-to-one-hot decode with range check; an out-of-range or invalid
// index yields an all-zero vector.
module instruction_index_decoder
  import trigger_issue_tracker_pkg::*;
(
  input  logic                                   i_valid,
  input  logic [TIA_INSTRUCTION_INDEX_WIDTH-1:0] i_index,
  output logic [TIA_MAX_NUM_INSTRUCTIONS-1:0]    o_one_hot,
  output logic                                   o_in_range
);

  // Full-width compare per bit so indices >= table size never alias.
  for (genvar gi = 0; gi < TIA_MAX_NUM_INSTRUCTIONS; gi++) begin : g_bit
    assign o_one_hot[gi] = i_valid && (i_index == TIA_INSTRUCTION_INDEX_WIDTH'(gi));
  end

  assign o_in_range = (int'(i_index) < TIA_MAX_NUM_INSTRUCTIONS);

endmodule

// File: rtl/trigger_issue_tracker.sv
// Tracks issued instructions through a fixed-depth execution pipeline and
// feeds back an in-flight mask so no instruction re-triggers before retiring.
module trigger_issue_tracker
  import trigger_issue_tracker_pkg::*;
#(
  parameter int NUM_STAGES = 3
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   triggered_instruction_valid,
  input  logic [TIA_INSTRUCTION_INDEX_WIDTH-1:0] triggered_instruction_index,
  input  logic                                   stall,
  input  logic                                   flush,
  output logic                                   issue_accept,
  output logic [TIA_MAX_NUM_INSTRUCTIONS-1:0]    issued_one_hot,
  output logic [TIA_MAX_NUM_INSTRUCTIONS-1:0]    in_flight_mask,
  output logic                                   retire_valid,
  output logic [TIA_INSTRUCTION_INDEX_WIDTH-1:0] retire_index,
  output logic                                   conflict_error
);

  issue_stage_t                        r_stage [NUM_STAGES];
  logic                                r_conflict;

  logic [TIA_MAX_NUM_INSTRUCTIONS-1:0] w_stage_one_hot  [NUM_STAGES];
  logic                                w_stage_in_range [NUM_STAGES];
  logic [TIA_MAX_NUM_INSTRUCTIONS-1:0] w_mask;
  logic [TIA_MAX_NUM_INSTRUCTIONS-1:0] w_trigger_one_hot;
  logic                                w_trigger_in_range;
  logic                                w_advance;
  logic                                w_trigger_blocked;
  logic                                w_accept;
  logic                                w_reject;

  for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_stage_dec
    instruction_index_decoder u_dec (
      .i_valid    (r_stage[gi].valid),
      .i_index    (r_stage[gi].index),
      .o_one_hot  (w_stage_one_hot[gi]),
      .o_in_range (w_stage_in_range[gi])
    );
  end

  instruction_index_decoder u_trigger_dec (
    .i_valid    (1'b1),
    .i_index    (triggered_instruction_index),
    .o_one_hot  (w_trigger_one_hot),
    .o_in_range (w_trigger_in_range)
  );

  always_comb begin
    w_mask = '0;
    for (int k = 0; k < NUM_STAGES; k++) begin
      if (w_stage_in_range[k]) w_mask = w_mask | w_stage_one_hot[k];
    end
  end

  // The retiring stage is part of the mask, so a retiring index waits one cycle.
  assign w_advance         = !stall && !flush;
  assign w_trigger_blocked = |(w_trigger_one_hot & w_mask);
  assign w_accept = triggered_instruction_valid && w_advance &&
                    w_trigger_in_range && !w_trigger_blocked;
  assign w_reject = triggered_instruction_valid && w_advance &&
                    (!w_trigger_in_range || w_trigger_blocked);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NUM_STAGES; k++) r_stage[k] <= '0;
    end else if (flush) begin
      for (int k = 0; k < NUM_STAGES; k++) r_stage[k] <= '0;
    end else if (!stall) begin
      r_stage[0] <= {w_accept, w_accept ? triggered_instruction_index : '0};
      for (int k = 1; k < NUM_STAGES; k++) r_stage[k] <= r_stage[k-1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)         r_conflict <= 1'b0;
    else if (w_reject) r_conflict <= 1'b1;
  end

  assign issue_accept   = w_accept;
  assign issued_one_hot = w_stage_one_hot[0];
  assign in_flight_mask = w_mask;
  // A flushed last-stage entry is dropped, not retired.
  assign retire_valid   = r_stage[NUM_STAGES-1].valid && w_advance;
  assign retire_index   = r_stage[NUM_STAGES-1].index;
  assign conflict_error = r_conflict;

endmodule

// File: tb/tb_trigger_issue_tracker.sv
// Directed bench for trigger_issue_tracker (16 instructions, 3 stages).
module tb_trigger_issue_tracker;
  import trigger_issue_tracker_pkg::*;

  logic                                   clk = 1'b0;
  logic                                   reset = 1'b1;
  logic                                   trig_valid = 1'b0;
  logic [TIA_INSTRUCTION_INDEX_WIDTH-1:0] trig_index = '0;
  logic                                   stall = 1'b0;
  logic                                   flush = 1'b0;
  logic                                   issue_accept;
  logic [TIA_MAX_NUM_INSTRUCTIONS-1:0]    issued_one_hot;
  logic [TIA_MAX_NUM_INSTRUCTIONS-1:0]    in_flight_mask;
  logic                                   retire_valid;
  logic [TIA_INSTRUCTION_INDEX_WIDTH-1:0] retire_index;
  logic                                   conflict_error;

  int checks = 0;
  int errors = 0;

  trigger_issue_tracker #(.NUM_STAGES(3)) dut (
    .clk                         (clk),
    .reset                       (reset),
    .triggered_instruction_valid (trig_valid),
    .triggered_instruction_index (trig_index),
    .stall                       (stall),
    .flush                       (flush),
    .issue_accept                (issue_accept),
    .issued_one_hot              (issued_one_hot),
    .in_flight_mask              (in_flight_mask),
    .retire_valid                (retire_valid),
    .retire_index                (retire_index),
    .conflict_error              (conflict_error)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; trig_valid = 1'b0; stall = 1'b0; flush = 1'b0;
    tick(); tick();
    reset = 1'b0;
    #1;
    checks++; if (issued_one_hot !== 16'h0) begin errors++; $display("FAIL reset_issued got %h want 0000", issued_one_hot); end
    checks++; if (in_flight_mask !== 16'h0) begin errors++; $display("FAIL reset_mask got %h want 0000", in_flight_mask); end
    checks++; if (retire_index !== 5'd0) begin errors++; $display("FAIL reset_retire_index got %0d want 0", retire_index); end
    checks++; if (retire_valid !== 1'b0) begin errors++; $display("FAIL reset_retire_valid got %b want 0", retire_valid); end
    checks++; if (conflict_error !== 1'b0) begin errors++; $display("FAIL reset_conflict got %b want 0", conflict_error); end
    checks++; if (issue_accept !== 1'b0) begin errors++; $display("FAIL reset_accept got %b want 0", issue_accept); end
    $display("test_reset done");
  endtask

  task automatic test_single();
    trig_valid = 1'b1; trig_index = 5'd5; #1;
    checks++; if (issue_accept !== 1'b1) begin errors++; $display("FAIL single_accept got %b want 1", issue_accept); end
    tick(); trig_valid = 1'b0; #1;
    checks++; if (issued_one_hot !== 16'h0020) begin errors++; $display("FAIL single_issued got %h want 0020", issued_one_hot); end
    checks++; if (in_flight_mask !== 16'h0020) begin errors++; $display("FAIL single_mask_t1 got %h want 0020", in_flight_mask); end
    checks++; if (retire_valid !== 1'b0) begin errors++; $display("FAIL single_retire_t1 got %b want 0", retire_valid); end
    tick(); #1;
    checks++; if (in_flight_mask !== 16'h0020) begin errors++; $display("FAIL single_mask_t2 got %h want 0020", in_flight_mask); end
    checks++; if (issued_one_hot !== 16'h0) begin errors++; $display("FAIL single_issued_t2 got %h want 0000", issued_one_hot); end
    tick(); #1;
    checks++; if (retire_valid !== 1'b1) begin errors++; $display("FAIL single_retire_valid got %b want 1", retire_valid); end
    checks++; if (retire_index !== 5'd5) begin errors++; $display("FAIL single_retire_index got %0d want 5", retire_index); end
    checks++; if (in_flight_mask !== 16'h0020) begin errors++; $display("FAIL single_mask_t3 got %h want 0020", in_flight_mask); end
    tick(); #1;
    checks++; if (in_flight_mask !== 16'h0) begin errors++; $display("FAIL single_mask_t4 got %h want 0000", in_flight_mask); end
    checks++; if (retire_valid !== 1'b0) begin errors++; $display("FAIL single_retire_t4 got %b want 0", retire_valid); end
    checks++; if (retire_index !== 5'd0) begin errors++; $display("FAIL single_retire_index_t4 got %0d want 0", retire_index); end
    $display("test_single done");
  endtask

  task automatic test_back_to_back();
    for (int i = 1; i <= 3; i++) begin
      trig_valid = 1'b1; trig_index = 5'(i); #1;
      checks++; if (issue_accept !== 1'b1) begin errors++; $display("FAIL b2b_accept_%0d got %b want 1", i, issue_accept); end
      tick();
    end
    trig_valid = 1'b0; #1;
    checks++; if (in_flight_mask !== 16'h000E) begin errors++; $display("FAIL b2b_mask_peak got %h want 000e", in_flight_mask); end
    for (int i = 1; i <= 3; i++) begin
      checks++; if (retire_valid !== 1'b1 || retire_index !== 5'(i)) begin errors++; $display("FAIL b2b_retire_%0d got v=%b i=%0d want v=1 i=%0d", i, retire_valid, retire_index, i); end
      tick(); #1;
    end
    checks++; if (in_flight_mask !== 16'h0 || retire_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got mask=%h rv=%b want 0000 0", in_flight_mask, retire_valid); end
    $display("test_back_to_back done");
  endtask

  task automatic test_stall();
    trig_valid = 1'b1; trig_index = 5'd7; #1;
    checks++; if (issue_accept !== 1'b1) begin errors++; $display("FAIL stall_accept got %b want 1", issue_accept); end
    tick();
    stall = 1'b1; trig_index = 5'd9; #1;
    checks++; if (issue_accept !== 1'b0) begin errors++; $display("FAIL stall_accept_blocked got %b want 0", issue_accept); end
    checks++; if (issued_one_hot !== 16'h0080) begin errors++; $display("FAIL stall_issued_t1 got %h want 0080", issued_one_hot); end
    tick(); #1;
    checks++; if (issued_one_hot !== 16'h0080) begin errors++; $display("FAIL stall_hold got %h want 0080", issued_one_hot); end
    checks++; if (retire_valid !== 1'b0) begin errors++; $display("FAIL stall_retire got %b want 0", retire_valid); end
    tick();
    stall = 1'b0; trig_valid = 1'b0; #1;
    checks++; if (issued_one_hot !== 16'h0080) begin errors++; $display("FAIL stall_issued_t3 got %h want 0080", issued_one_hot); end
    tick(); #1;
    checks++; if (retire_valid !== 1'b0) begin errors++; $display("FAIL stall_retire_t4 got %b want 0", retire_valid); end
    tick(); #1;
    checks++; if (retire_valid !== 1'b1 || retire_index !== 5'd7) begin errors++; $display("FAIL stall_retire_t5 got v=%b i=%0d want v=1 i=7", retire_valid, retire_index); end
    checks++; if (conflict_error !== 1'b0) begin errors++; $display("FAIL stall_conflict got %b want 0", conflict_error); end
    tick(); #1;
    checks++; if (in_flight_mask !== 16'h0) begin errors++; $display("FAIL stall_drain got %h want 0000", in_flight_mask); end
    $display("test_stall done");
  endtask

  task automatic test_flush();
    for (int i = 10; i <= 12; i++) begin
      trig_valid = 1'b1; trig_index = 5'(i); tick();
    end
    #1;
    checks++; if (in_flight_mask !== 16'h1C00) begin errors++; $display("FAIL flush_pre_mask got %h want 1c00", in_flight_mask); end
    flush = 1'b1; trig_index = 5'd13; #1;
    checks++; if (issue_accept !== 1'b0) begin errors++; $display("FAIL flush_accept got %b want 0", issue_accept); end
    checks++; if (retire_valid !== 1'b0) begin errors++; $display("FAIL flush_retire got %b want 0", retire_valid); end
    tick();
    flush = 1'b0; trig_valid = 1'b0; #1;
    checks++; if (in_flight_mask !== 16'h0) begin errors++; $display("FAIL flush_mask got %h want 0000", in_flight_mask); end
    checks++; if (retire_valid !== 1'b0) begin errors++; $display("FAIL flush_retire_after got %b want 0", retire_valid); end
    checks++; if (conflict_error !== 1'b0) begin errors++; $display("FAIL flush_conflict got %b want 0", conflict_error); end
    tick(); #1;
    checks++; if (in_flight_mask !== 16'h0) begin errors++; $display("FAIL flush_mask_t2 got %h want 0000", in_flight_mask); end
    $display("test_flush done");
  endtask

  task automatic test_conflict();
    trig_valid = 1'b1; trig_index = 5'd4; #1;
    checks++; if (issue_accept !== 1'b1) begin errors++; $display("FAIL conflict_accept_t0 got %b want 1", issue_accept); end
    tick(); #1;
    checks++; if (issue_accept !== 1'b0) begin errors++; $display("FAIL conflict_reject_t1 got %b want 0", issue_accept); end
    tick(); #1;
    checks++; if (issue_accept !== 1'b0) begin errors++; $display("FAIL conflict_reject_t2 got %b want 0", issue_accept); end
    checks++; if (conflict_error !== 1'b1) begin errors++; $display("FAIL conflict_sticky got %b want 1", conflict_error); end
    tick(); #1;
    checks++; if (issue_accept !== 1'b0) begin errors++; $display("FAIL conflict_reject_t3 got %b want 0", issue_accept); end
    checks++; if (retire_valid !== 1'b1 || retire_index !== 5'd4) begin errors++; $display("FAIL conflict_retire got v=%b i=%0d want v=1 i=4", retire_valid, retire_index); end
    tick(); #1;
    checks++; if (issue_accept !== 1'b1) begin errors++; $display("FAIL conflict_reaccept got %b want 1", issue_accept); end
    tick();
    trig_valid = 1'b0; #1;
    checks++; if (conflict_error !== 1'b1) begin errors++; $display("FAIL conflict_still_set got %b want 1", conflict_error); end
    $display("test_conflict done");
  endtask

  task automatic test_out_of_range_and_async_reset();
    reset = 1'b1; tick(); reset = 1'b0; #1;
    checks++; if (conflict_error !== 1'b0) begin errors++; $display("FAIL oor_reset_conflict got %b want 0", conflict_error); end
    trig_valid = 1'b1; trig_index = 5'd20; #1;
    checks++; if (issue_accept !== 1'b0) begin errors++; $display("FAIL oor_accept got %b want 0", issue_accept); end
    tick(); #1;
    checks++; if (conflict_error !== 1'b1) begin errors++; $display("FAIL oor_conflict got %b want 1", conflict_error); end
    checks++; if (in_flight_mask !== 16'h0) begin errors++; $display("FAIL oor_mask got %h want 0000", in_flight_mask); end
    trig_index = 5'd15; #1;
    checks++; if (issue_accept !== 1'b1) begin errors++; $display("FAIL oor_top_index_accept got %b want 1", issue_accept); end
    tick();
    trig_index = 5'd0; tick();
    trig_valid = 1'b0; #1;
    checks++; if (in_flight_mask !== 16'h8001) begin errors++; $display("FAIL async_pre_mask got %h want 8001", in_flight_mask); end
    #2 reset = 1'b1; #1;
    checks++; if (in_flight_mask !== 16'h0 || issued_one_hot !== 16'h0) begin errors++; $display("FAIL async_clear got mask=%h issued=%h want 0000 0000", in_flight_mask, issued_one_hot); end
    checks++; if (retire_index !== 5'd0 || conflict_error !== 1'b0) begin errors++; $display("FAIL async_clear2 got ri=%0d ce=%b want 0 0", retire_index, conflict_error); end
    tick(); reset = 1'b0;
    $display("test_out_of_range_and_async_reset done");
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_flush();
    test_conflict();
    test_out_of_range_and_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/trigger_issue_tracker.md
# trigger_issue_tracker

Decode-side partner of the PE trigger resolution stage. Takes the resolved instruction index and valid, decodes it to a one-hot issue vector, and tracks each issued instruction through a fixed-depth execution pipeline. It feeds back an in-flight mask so the trigger resolution stage does not re-trigger an instruction until that instruction retires. Sits between trigger resolution and the PE datapath, one instance per PE.

## Interface
- NUM_STAGES, 3, issue-to-retire pipeline depth in cycles; legal range 1..8.
- clk  input  1  PE clock; all state is updated on the rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- triggered_instruction_valid  input  1  resolution found a triggered instruction this cycle.
- triggered_instruction_index  input  TIA_INSTRUCTION_INDEX_WIDTH  index of the triggered instruction.
- stall  input  1  datapath back-pressure; freezes all stages.
- flush  input  1  drops every in-flight instruction; used on halt or reprogramming.
- issue_accept  output  1  combinational; the current trigger is accepted this cycle.
- issued_one_hot  output  TIA_MAX_NUM_INSTRUCTIONS  registered one-hot of the instruction in stage 0; zero when stage 0 is empty.
- in_flight_mask  output  TIA_MAX_NUM_INSTRUCTIONS  OR of the one-hots of all occupied stages.
- retire_valid  output  1  combinational; the last stage holds an instruction and stall=0.
- retire_index  output  TIA_INSTRUCTION_INDEX_WIDTH  index in the last stage; 0 when the last stage is empty.
- conflict_error  output  1  sticky; set on any rejected in-range re-trigger or any out-of-range index.

## Operation
- State: NUM_STAGES entries, each holding {valid, index}. Plus the sticky conflict_error.
- Acceptance: issue_accept = triggered_instruction_valid & !stall & !flush & in_range & !in_flight_mask[index].
  - in_range means index < TIA_MAX_NUM_INSTRUCTIONS.
- Advance when stall=0 and flush=0:
  - stage[k] <= stage[k-1] for k ≥ 1.
  - stage[0] <= {issue_accept, issue_accept ? index : 0}.
  - The last-stage entry leaves the pipeline, reported as retire_valid/retire_index.
- stall=1 and flush=0: every stage holds its value and nothing is accepted. retire_valid=0.
- flush=1: every stage clears to {0,0} on the next edge, whatever stall and trigger are doing. Priority is reset > flush > stall.
- Re-trigger blocking:
  - The mask includes the last stage, so an index that is retiring cannot re-issue in that same cycle. It can re-issue on the following cycle.
  - A valid trigger rejected by the mask, with stall=0 and flush=0, sets conflict_error. Upstream masking is expected to make this unreachable.
- Out-of-range index with valid=1, stall=0 and flush=0: rejected, and conflict_error is set.
- The one-hot decode uses a full compare over all TIA_MAX_NUM_INSTRUCTIONS bits. An out-of-range index decodes to all zeros.
- conflict_error clears only on reset.

## Timing
- Reset values: every stage {0,0}. issued_one_hot=0, in_flight_mask=0, retire_index=0, conflict_error=0. issue_accept and retire_valid are 0 while the stages are empty.
- Trigger accepted at edge t, with no stalls:
  - issued_one_hot shows the instruction during cycle t+1.
  - retire_valid=1 during cycle t+NUM_STAGES.
  - The mask bit is set from t+1 through t+NUM_STAGES and clear from t+NUM_STAGES+1.
- Each stall cycle adds one cycle of latency.
- Throughput is one issue per cycle, provided the indices differ.
- Asserting reset mid-operation clears all state immediately, without waiting for a clock edge.
- A trigger arriving together with flush is dropped, and conflict_error is not set.

## Structure
- Take TIA_MAX_NUM_INSTRUCTIONS and TIA_INSTRUCTION_INDEX_WIDTH from the shared control header.
- Add a packed struct issue_stage_t {logic valid; logic [TIA_INSTRUCTION_INDEX_WIDTH-1:0] index;} to the control package.
- One natural sub-module, instruction_index_decoder: combinational index-to-one-hot with range check. It is instantiated once per stage to form the mask.

## Test plan
- Reset, then trigger index 5 (TIA_MAX_NUM_INSTRUCTIONS=16, NUM_STAGES=3) -> issue_accept=1; issued_one_hot=0x0020 at t+1; retire_valid=1 with retire_index=5 at t+3; mask 0x0020 over t+1..t+3, then 0.
- Back-to-back triggers 1, 2, 3 -> all accepted; mask peaks at 0x000E; retires in order 1, 2, 3 on consecutive cycles.
- Trigger 4 held valid every cycle -> accepted at t; rejected t+1..t+3 with conflict_error=1 from t+1; re-accepted at t+4.
- Stall asserted for 2 cycles after issuing 7 -> the entry holds; retire_valid=0 while stalled; retire at t+5.
- Flush with 3 instructions in flight plus a new trigger -> mask=0 next cycle; no retire; conflict_error unchanged.
- Out-of-range index 20 (with INDEX_WIDTH=5) -> issue_accept=0, conflict_error=1; reset asserted mid-pipeline clears all outputs without a clock edge.
